vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Generates VGA 640x480 timing and sequences Pixel_Generator by driving X_PIX, Y_PIX, Video_On, X_SH and Y_SH.
- Outputs HSync/VSync to the connector.
- Takes display-shift updates from the control/audio side over a valid/ready handshake.
- Applies an accepted shift only at a frame boundary, so the picture never tears mid-frame.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1; 2 gives 25 MHz from 50 MHz).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Shift_Valid  in  1  new shift pair offered.
- X_SH_In  in  10  offered horizontal shift.
- Y_SH_In  in  10  offered vertical shift.
- Shift_Ready  out  1  block can accept a shift.
- X_PIX  out  10  current horizontal count, 0..H_TOTAL-1.
- Y_PIX  out  10  current vertical count, 0..V_TOTAL-1.
- Video_On  out  1  current pixel is in the visible area.
- HSync  out  1  horizontal sync, active low.
- VSync  out  1  vertical sync, active low.
- Pix_En  out  1  one-clk pulse: coordinates changed this cycle.
- Frame_Start  out  1  one-clk pulse: coordinates just became (0,0).
- X_SH  out  10  applied horizontal shift, stable for a whole frame.
- Y_SH  out  10  applied vertical shift, stable for a whole frame.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values (asynchronous, immediate on rst_n low): div=0, X_PIX=H_TOTAL-1 (799), Y_PIX=V_TOTAL-1 (524), Video_On=0, HSync=1, VSync=1, Pix_En=0, Frame_Start=0, X_SH=0, Y_SH=0, pending empty, Shift_Ready=1.
- Divider: div counts 0..CLK_DIV-1 and wraps. The "advance edge" is the edge where div==CLK_DIV-1; for CLK_DIV=1 every edge is an advance edge.
- On an advance edge:
  - X_PIX increments; at H_TOTAL-1 it wraps to 0 and Y_PIX increments.
  - Y_PIX wraps from V_TOTAL-1 to 0.
- Decodes: Video_On, HSync and VSync are registered and updated on the same edge from the next coordinate values, so they are always consistent with X_PIX/Y_PIX in the same cycle. No extra latency.
  - Video_On = (X_PIX<H_ACTIVE) && (Y_PIX<V_ACTIVE).
  - HSync = 0 iff H_ACTIVE+H_FP ≤ X_PIX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - VSync = 0 iff V_ACTIVE+V_FP ≤ Y_PIX < V_ACTIVE+V_FP+V_SYNC (490..491).
- Pix_En = 1 for the single clk following each advance edge, 0 otherwise.
- Frame_Start = 1 only in the Pix_En cycle where (X_PIX,Y_PIX)=(0,0).
- First frame after reset: the first advance edge, CLK_DIV clks after rst_n release, produces (0,0) with Frame_Start=1.
- Shift handshake FSM:
  - EMPTY: Shift_Ready=1. On Shift_Valid=1, capture X_SH_In/Y_SH_In into the pending register and go to HELD.
  - HELD: Shift_Ready=0; Shift_Valid is ignored. On the advance edge that wraps to (0,0), X_SH/Y_SH load the pending values on that same edge, so they change together with Frame_Start. Return to EMPTY; Shift_Ready=1 from the next cycle.
- Simultaneous events:
  - Valid accepted in EMPTY on the wrap edge: captured only, applied at the following frame start.
  - Valid held high in HELD across the wrap: not accepted on that edge; accepted on the next edge if still high.
- Data values are taken verbatim, with no range clamping. X_SH/Y_SH never change except at a frame wrap or on reset.
- Reset mid-frame: all state returns to the reset values; a pending shift is discarded.

Test Plan:
- Reset: hold rst_n=0 for 5 clks → X_PIX=799, Y_PIX=524, HSync=VSync=1, Video_On=0, Shift_Ready=1, X_SH=Y_SH=0. Release → Frame_Start and Pix_En pulse together at clk 2 with X_PIX=Y_PIX=0, Video_On=1.
- Line timing (CLK_DIV=2):
  - Pix_En has period 2 clks; one line = 1600 clks.
  - Video_On is high for X_PIX 0..639 and low for 640..799.
  - HSync is low for exactly 96 pixels, from X_PIX=656 through 751.
- Frame timing:
  - Frame_Start period is exactly 840000 clks.
  - VSync is low only for Y_PIX 490..491, i.e. 1600 pixels.
  - Video_On is never high for Y_PIX ≥ 480.
- Shift apply: at Y_PIX=100, pulse Shift_Valid with X_SH_In=37, Y_SH_In=12.
  - Shift_Ready falls the next clk; X_SH/Y_SH stay 0/0 until the Frame_Start cycle, then become 37/12.
  - Shift_Ready returns to 1 one clk later.
- Back-pressure: offer (5,5), then hold Valid high with (9,9) for the rest of the frame.
  - At the frame start (5,5) is applied and (9,9) is accepted the next clk.
  - (9,9) is applied at the following frame start.
- Mid-frame reset: with X_PIX=300, Y_PIX=200 and a shift pending, pulse rst_n low for 1 clk.
  - All outputs return to the reset values asynchronously.
  - After release, the pending shift is never applied: X_SH stays 0 through 2 frames.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel/line counters, registered sync and blanking
// decodes, and a valid/ready shift register that only changes at frame wrap.
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Shift_Valid,
  input  logic [9:0] X_SH_In,
  input  logic [9:0] Y_SH_In,
  output logic       Shift_Ready,
  output logic [9:0] X_PIX,
  output logic [9:0] Y_PIX,
  output logic       Video_On,
  output logic       HSync,
  output logic       VSync,
  output logic       Pix_En,
  output logic       Frame_Start,
  output logic [9:0] X_SH,
  output logic [9:0] Y_SH
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } shift_state_t;

  logic [DIV_W-1:0] div;
  logic             advance;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             frame_wrap;

  shift_state_t     state;
  shift_state_t     state_next;
  logic             capture;
  logic             apply;
  logic [9:0]       pend_x;
  logic [9:0]       pend_y;

  assign advance     = (div == DIV_LAST);
  assign frame_wrap  = advance && (X_PIX == H_LAST) && (Y_PIX == V_LAST);
  assign Shift_Ready = (state == ST_EMPTY);

  // Pixel clock divider; the advance edge is the last count of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (advance) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Next coordinate, stepping only on advance edges and wrapping at totals.
  always_comb begin
    x_next = X_PIX;
    y_next = Y_PIX;
    if (advance) begin
      if (X_PIX == H_LAST) begin
        x_next = 10'd0;
        y_next = (Y_PIX == V_LAST) ? 10'd0 : Y_PIX + 1'b1;
      end else begin
        x_next = X_PIX + 1'b1;
      end
    end
  end

  // Coordinates plus decodes registered together so they always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_PIX       <= H_LAST;
      Y_PIX       <= V_LAST;
      Video_On    <= 1'b0;
      HSync       <= 1'b1;
      VSync       <= 1'b1;
      Pix_En      <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      X_PIX       <= x_next;
      Y_PIX       <= y_next;
      Video_On    <= (x_next < H_VIS) && (y_next < V_VIS);
      HSync       <= !((x_next >= H_SYNC_BEG) && (x_next < H_SYNC_END));
      VSync       <= !((y_next >= V_SYNC_BEG) && (y_next < V_SYNC_END));
      Pix_En      <= advance;
      Frame_Start <= frame_wrap;
    end
  end

  // Shift handshake decisions: accept when empty, release at frame wrap.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    apply      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (Shift_Valid) begin
          capture    = 1'b1;
          state_next = ST_HELD;
        end
      end
      ST_HELD: begin
        if (frame_wrap) begin
          apply      = 1'b1;
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Handshake state, pending pair and the applied shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      pend_x <= '0;
      pend_y <= '0;
      X_SH   <= '0;
      Y_SH   <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        pend_x <= X_SH_In;
        pend_y <= Y_SH_In;
      end
      if (apply) begin
        X_SH <= pend_x;
        Y_SH <= pend_y;
      end
    end
  end

endmodule
